relu_stream_stage: RTL and testbench

//  Parametrised activation/output stage after the systolic MAC array. Takes one tagged result
//  per cycle, requantises (arithmetic shift), applies ReLU / leaky ReLU / pass-through with

---
 rtl/relu_stream_if.sv | 47 ++++
 rtl/relu_stream_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_relu_stream_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/relu_stream_if.sv
// relu_stream_if: result input bus plus the output valid/ready
// handshake of the activation stage.
interface relu_stream_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int INDEX_WIDTH  = 8
);
  logic [RESULT_WIDTH:0]   input_result;
  logic [1:0]              mode;
  logic                    index_clear;
  logic                    input_ready;
  logic                    output_valid;
  logic                    output_ready;
  logic [DATA_WIDTH-1:0]   output_value;
  logic [INDEX_WIDTH-1:0]  output_index;
  logic                    output_last;
  logic                    overflow;
  logic                    clear_overflow;

  modport master (
    output input_result,
    output mode,
    output index_clear,
    output output_ready,
    output clear_overflow,
    input  input_ready,
    input  output_valid,
    input  output_value,
    input  output_index,
    input  output_last,
    input  overflow
  );

  modport slave (
    input  input_result,
    input  mode,
    input  index_clear,
    input  output_ready,
    input  clear_overflow,
    output input_ready,
    output output_valid,
    output output_value,
    output output_index,
    output output_last,
    output overflow
  );
endinterface

// File: rtl/relu_stream_stage.sv
// relu_stream_stage: requantise, activate, saturate, index and
// buffer MAC results behind a valid/ready output FIFO.
module relu_stream_stage #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int CELL_AMOUNT  = 4,
  parameter int INDEX_WIDTH  = 8,
  parameter int SHIFT        = 0,
  parameter int LEAK_SHIFT   = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  relu_stream_if.slave bus
);
  localparam int LP_AW = $clog2(FIFO_DEPTH);
  localparam int LP_CW = LP_AW + 1;
  localparam int LP_OW = LP_CW + 1;
  localparam int LP_W  =
    ((RESULT_WIDTH > DATA_WIDTH) ? RESULT_WIDTH : DATA_WIDTH) + 2;

  localparam logic [INDEX_WIDTH-1:0] LP_LAST =
    INDEX_WIDTH'(CELL_AMOUNT - 1);
  localparam logic signed [LP_W-1:0] LP_UMAX =
    LP_W'((64'sd1 <<< DATA_WIDTH) - 64'sd1);
  localparam logic signed [LP_W-1:0] LP_SMAX =
    LP_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [LP_W-1:0] LP_SMIN =
    LP_W'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  // input side
  logic                           w_in_valid;
  logic signed [RESULT_WIDTH-1:0] w_in_data;
  logic                           w_leaky;
  logic                           w_pass;
  logic [LP_OW-1:0]               w_occ;
  logic                           w_ready;
  logic                           w_accept;
  logic                           w_drop;
  logic [INDEX_WIDTH-1:0]         w_idx;
  logic signed [RESULT_WIDTH-1:0] w_shift;
  logic signed [RESULT_WIDTH-1:0] w_act;

  // stage 1: activated, not yet saturated
  logic                           r_s1_valid;
  logic                           r_s1_sgn;
  logic signed [RESULT_WIDTH-1:0] r_s1_val;
  logic [INDEX_WIDTH-1:0]         r_s1_idx;

  logic signed [LP_W-1:0]         w_ext;
  logic signed [LP_W-1:0]         w_clamp;
  logic                           w_unused;

  // stage 2: saturated, ready for the FIFO
  logic                           r_s2_valid;
  logic [DATA_WIDTH-1:0]          r_s2_val;
  logic [INDEX_WIDTH-1:0]         r_s2_idx;
  logic                           r_s2_last;

  // index counter and sticky drop flag
  logic [INDEX_WIDTH-1:0]         r_idx;
  logic                           r_ovf;

  // output FIFO
  logic [DATA_WIDTH-1:0]          r_mem_val  [FIFO_DEPTH];
  logic [INDEX_WIDTH-1:0]         r_mem_idx  [FIFO_DEPTH];
  logic                           r_mem_last [FIFO_DEPTH];
  logic [LP_AW-1:0]               r_wptr;
  logic [LP_AW-1:0]               r_rptr;
  logic [LP_CW-1:0]               r_count;
  logic                           w_out_valid;
  logic                           w_push;
  logic                           w_pop;

  assign w_in_valid = bus.input_result[RESULT_WIDTH];
  assign w_in_data  = bus.input_result[RESULT_WIDTH-1:0];
  assign w_leaky    = (bus.mode == 2'b01);
  assign w_pass     = (bus.mode == 2'b10);

  // Everything in flight counts, so a beat accepted now
  // always has a FIFO slot by the time it arrives.
  assign w_occ = {1'b0, r_count}
               + LP_OW'(r_s1_valid)
               + LP_OW'(r_s2_valid);
  assign w_ready  = rst_n && (w_occ < LP_OW'(FIFO_DEPTH));
  assign w_accept = w_in_valid && w_ready;
  assign w_drop   = w_in_valid && !w_ready;
  assign w_idx    = bus.index_clear ? '0 : r_idx;

  // requantise and apply the activation for the selected mode
  always_comb begin
    w_shift = w_in_data >>> SHIFT;
    w_act   = w_shift;
    unique case (1'b1)
      w_pass:  w_act = w_shift;
      w_leaky: begin
        if (w_shift[RESULT_WIDTH-1])
          w_act = w_shift >>> LEAK_SHIFT;
      end
      default: begin
        if (w_shift[RESULT_WIDTH-1])
          w_act = '0;
      end
    endcase
  end

  // stage 1 register: activated value, mode class, index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sgn   <= 1'b0;
      r_s1_val   <= '0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sgn <= w_leaky || w_pass;
        r_s1_val <= w_act;
        r_s1_idx <= w_idx;
      end
    end
  end

  assign w_ext = {{(LP_W-RESULT_WIDTH){r_s1_val[RESULT_WIDTH-1]}},
                  r_s1_val};

  // saturate: signed range for LEAKY/PASS, unsigned for RELU
  always_comb begin
    w_clamp = w_ext;
    unique case (1'b1)
      r_s1_sgn: begin
        if (w_ext > LP_SMAX)
          w_clamp = LP_SMAX;
        else if (w_ext < LP_SMIN)
          w_clamp = LP_SMIN;
      end
      default: begin
        if (w_ext > LP_UMAX)
          w_clamp = LP_UMAX;
        else if (w_ext[LP_W-1])
          w_clamp = '0;
      end
    endcase
  end

  assign w_unused = ^w_clamp[LP_W-1:DATA_WIDTH];

  // stage 2 register: final value with index and last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_val   <= '0;
      r_s2_idx   <= '0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_val  <= w_clamp[DATA_WIDTH-1:0];
        r_s2_idx  <= r_s1_idx;
        r_s2_last <= (r_s1_idx == LP_LAST);
      end
    end
  end

  // cell index: advances per accepted beat, wraps at the last cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_accept) begin
      if (w_idx == LP_LAST)
        r_idx <= '0;
      else
        r_idx <= w_idx + INDEX_WIDTH'(1);
    end else if (bus.index_clear) begin
      r_idx <= '0;
    end
  end

  // sticky drop flag; a drop outranks a clear on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (bus.clear_overflow)
      r_ovf <= 1'b0;
  end

  assign w_out_valid = (r_count != '0);
  assign w_push      = r_s2_valid;
  assign w_pop       = w_out_valid && bus.output_ready;

  // FIFO storage; contents are only visible through a valid head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_val[r_wptr]  <= r_s2_val;
      r_mem_idx[r_wptr]  <= r_s2_idx;
      r_mem_last[r_wptr] <= r_s2_last;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + LP_AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + LP_AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + LP_CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - LP_CW'(1);
    end
  end

  assign bus.input_ready  = w_ready;
  assign bus.overflow     = r_ovf;
  assign bus.output_valid = w_out_valid;
  assign bus.output_value =
    w_out_valid ? r_mem_val[r_rptr] : '0;
  assign bus.output_index =
    w_out_valid ? r_mem_idx[r_rptr] : '0;
  assign bus.output_last  =
    w_out_valid ? r_mem_last[r_rptr] : 1'b0;
endmodule

// File: tb/tb_relu_stream_stage.sv
// tb_relu_stream_stage: directed vectors for the activation
// stage, default build plus a SHIFT=4 build.
module tb_relu_stream_stage;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  relu_stream_if #(.DATA_WIDTH(8), .RESULT_WIDTH(16),
                   .INDEX_WIDTH(8)) if0 ();
  relu_stream_if #(.DATA_WIDTH(8), .RESULT_WIDTH(16),
                   .INDEX_WIDTH(8)) if4 ();

  relu_stream_stage #(
    .DATA_WIDTH(8), .RESULT_WIDTH(16), .CELL_AMOUNT(4),
    .INDEX_WIDTH(8), .SHIFT(0), .LEAK_SHIFT(3), .FIFO_DEPTH(4)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  relu_stream_stage #(
    .DATA_WIDTH(8), .RESULT_WIDTH(16), .CELL_AMOUNT(4),
    .INDEX_WIDTH(8), .SHIFT(4), .LEAK_SHIFT(3), .FIFO_DEPTH(4)
  ) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  // test 1: RELU, back-to-back
  int t1_in  [5] = '{5, -3, 300, 64, 7};
  int t1_val [5] = '{5, 0, 255, 64, 7};
  int t1_idx [5] = '{0, 1, 2, 3, 0};
  // test 2: LEAKY; index continues from test 1
  int t2_in  [4] = '{-64, -1, 200, -4000};
  int t2_val [4] = '{'hF8, 'hFF, 'h7F, 'h80};
  int t2_idx [4] = '{1, 2, 3, 0};
  // test 4: index_clear with the second beat
  int t4_idx [6] = '{0, 0, 1, 2, 3, 0};
  // test 6: SHIFT=4, per-beat modes
  int t6_in  [7] = '{-1000, 'h7FFF, -1000, 'h7FFF,
                     -1000, 800, 100};
  int t6_md  [7] = '{2, 2, 0, 0, 1, 1, 2};
  int t6_val [7] = '{'hC1, 'h7F, 0, 'hFF, 'hF8, 'h32, 'h06};
  int t6_idx [7] = '{0, 1, 2, 3, 0, 1, 2};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag,
                          input bit sel,
                          input int val,
                          input int idx);
    if (sel) begin
      chk({tag, ".v"}, 32'(if4.output_valid), 32'd1);
      chk({tag, ".val"}, 32'(if4.output_value), 32'(val & 'hFF));
      chk({tag, ".idx"}, 32'(if4.output_index), 32'(idx));
      chk({tag, ".last"}, 32'(if4.output_last), 32'(idx == 3));
    end else begin
      chk({tag, ".v"}, 32'(if0.output_valid), 32'd1);
      chk({tag, ".val"}, 32'(if0.output_value), 32'(val & 'hFF));
      chk({tag, ".idx"}, 32'(if0.output_index), 32'(idx));
      chk({tag, ".last"}, 32'(if0.output_last), 32'(idx == 3));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input int d,
                      input logic [1:0] m);
    if0.input_result = {v, 16'(d)};
    if0.mode         = m;
  endtask

  task automatic drv4(input logic v, input int d,
                      input logic [1:0] m);
    if4.input_result = {v, 16'(d)};
    if4.mode         = m;
  endtask

  initial begin
    drv0(1'b0, 0, 2'b00);
    drv4(1'b0, 0, 2'b00);
    if0.index_clear    = 1'b0;
    if0.output_ready   = 1'b1;
    if0.clear_overflow = 1'b0;
    if4.index_clear    = 1'b0;
    if4.output_ready   = 1'b1;
    if4.clear_overflow = 1'b0;

    // reset state
    #2;
    chk("rst.valid", 32'(if0.output_valid), 32'd0);
    chk("rst.value", 32'(if0.output_value), 32'd0);
    chk("rst.ovf", 32'(if0.overflow), 32'd0);
    step();
    step();
    #3 rst_n = 1'b1;
    #1;
    chk("rel.ready", 32'(if0.input_ready), 32'd1);
    chk("rel.valid", 32'(if0.output_valid), 32'd0);
    step();

    // test 1: RELU stream, latency and wrap
    for (int k = 0; k < 7; k++) begin
      if (k < 5) drv0(1'b1, t1_in[k], 2'b00);
      else       drv0(1'b0, 0, 2'b00);
      step();
      if (k < 2)
        chk("t1.lat", 32'(if0.output_valid), 32'd0);
      else
        chk_head("t1", 1'b0, t1_val[k-2], t1_idx[k-2]);
    end
    step();
    chk("t1.empty", 32'(if0.output_valid), 32'd0);

    // test 2: LEAKY
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drv0(1'b1, t2_in[k], 2'b01);
      else       drv0(1'b0, 0, 2'b01);
      step();
      if (k >= 2)
        chk_head("t2", 1'b0, t2_val[k-2], t2_idx[k-2]);
    end
    step();
    chk("t2.empty", 32'(if0.output_valid), 32'd0);

    // test 3: backpressure, drops, drain, clear
    if0.index_clear = 1'b1;
    step();
    if0.index_clear  = 1'b0;
    if0.output_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("t3.ready", 32'(if0.input_ready), 32'(k < 4));
      drv0(1'b1, 10 + k, 2'b00);
      step();
    end
    drv0(1'b0, 0, 2'b00);
    chk("t3.ovf", 32'(if0.overflow), 32'd1);
    chk_head("t3.hold0", 1'b0, 10, 0);
    step();
    chk_head("t3.hold1", 1'b0, 10, 0);
    if0.output_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk_head("t3.drain", 1'b0, 10 + k, k);
    end
    step();
    chk("t3.empty", 32'(if0.output_valid), 32'd0);
    chk("t3.ready2", 32'(if0.input_ready), 32'd1);
    chk("t3.ovfkeep", 32'(if0.overflow), 32'd1);
    if0.clear_overflow = 1'b1;
    step();
    if0.clear_overflow = 1'b0;
    chk("t3.ovfclr", 32'(if0.overflow), 32'd0);

    // test 4: index_clear with the 2nd beat
    for (int k = 0; k < 8; k++) begin
      if (k < 6) drv0(1'b1, k + 1, 2'b00);
      else       drv0(1'b0, 0, 2'b00);
      if0.index_clear = (k == 1);
      step();
      if (k >= 2)
        chk_head("t4", 1'b0, k - 1, t4_idx[k-2]);
    end
    if0.index_clear = 1'b0;
    step();
    chk("t4.empty", 32'(if0.output_valid), 32'd0);

    // test 5: reset with buffered beats
    if0.output_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv0(1'b1, 20 + k, 2'b00);
      step();
    end
    drv0(1'b0, 0, 2'b00);
    step();
    step();
    chk_head("t5.buf", 1'b0, 20, 1);
    rst_n = 1'b0;
    #1;
    chk("t5.valid", 32'(if0.output_valid), 32'd0);
    chk("t5.value", 32'(if0.output_value), 32'd0);
    chk("t5.index", 32'(if0.output_index), 32'd0);
    chk("t5.last", 32'(if0.output_last), 32'd0);
    step();
    #3 rst_n = 1'b1;
    #1;
    chk("t5.ready", 32'(if0.input_ready), 32'd1);
    chk("t5.empty", 32'(if0.output_valid), 32'd0);
    step();
    if0.output_ready = 1'b1;
    drv0(1'b1, 30, 2'b00);
    step();
    drv0(1'b0, 0, 2'b00);
    step();
    step();
    chk_head("t5.next", 1'b0, 30, 0);

    // test 6: SHIFT=4 build, mixed modes
    for (int k = 0; k < 9; k++) begin
      if (k < 7) drv4(1'b1, t6_in[k], 2'(t6_md[k]));
      else       drv4(1'b0, 0, 2'b00);
      step();
      if (k >= 2)
        chk_head("t6", 1'b1, t6_val[k-2], t6_idx[k-2]);
    end
    step();
    chk("t6.empty", 32'(if4.output_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
